// File: rtl/ldpc_enc_top_if.sv
// Encoder bus: start/message handshake, codeword output and P-matrix ROM read port.
// master = requester plus ROM side, slave = the encoder.
interface ldpc_enc_top_if #(
  parameter int unsigned K  = 128,
  parameter int unsigned AW = 7
);
  logic           work;
  logic [K-1:0]   msg;
  logic           free;
  logic [2*K-1:0] enout;
  logic           valid;
  logic           rom_en;
  logic [AW-1:0]  rom_addr;
  logic [K-1:0]   rom_data;

  modport master (
    output work, msg, rom_data,
    input  free, enout, valid, rom_en, rom_addr
  );

  modport slave (
    input  work, msg, rom_data,
    output free, enout, valid, rom_en, rom_addr
  );
endinterface

// File: rtl/ldpc_enc_top.sv
// Systematic rate-1/2 LDPC encoder: parity = XOR of P rows selected by message bits,
// one row per cycle from a 1-cycle-latency ROM; emits {parity, message}.
module ldpc_enc_top #(
  parameter int unsigned K  = 128,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  ldpc_enc_top_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  localparam logic [AW:0] LastRow = (AW+1)'(K - 1);

  state_e         r_state, w_state_d;
  logic [AW:0]    r_cnt;
  logic [K-1:0]   r_msg_buf;
  logic [K-1:0]   r_par;
  logic [K-1:0]   w_par_acc;
  logic [2*K-1:0] r_enout;
  logic           r_valid;
  logic [AW-1:0]  r_addr_hold;
  logic           r_rd_vld;
  logic [AW-1:0]  r_rd_row;
  logic           w_accept;
  logic           w_fetch;
  logic           w_last;

  always_comb begin
    w_fetch   = (r_state == StFetch);
    w_accept  = (r_state == StIdle) && bus.work;
    w_last    = w_fetch && (r_cnt == LastRow);
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StFetch;
      StFetch: if (w_last)   w_state_d = StDrain;
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Row data lands one cycle after its read; r_rd_row says which message bit gates it.
  always_comb begin
    w_par_acc = r_par;
    if (r_rd_vld && r_msg_buf[r_rd_row]) begin
      w_par_acc = r_par ^ bus.rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_msg_buf   <= '0;
      r_par       <= '0;
      r_enout     <= '0;
      r_valid     <= 1'b0;
      r_addr_hold <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_row    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rd_vld <= w_fetch;
      r_rd_row <= r_cnt[AW-1:0];
      r_valid  <= (r_state == StDrain);
      if (w_accept) begin
        r_msg_buf <= bus.msg;
        r_par     <= '0;
        r_cnt     <= '0;
      end else begin
        r_par <= w_par_acc;
      end
      if (w_fetch) begin
        r_cnt       <= r_cnt + 1'b1;
        r_addr_hold <= r_cnt[AW-1:0];
      end
      if (r_state == StDrain) begin
        r_enout <= {w_par_acc, r_msg_buf};
      end
    end
  end

  // Outside FETCH the address port keeps showing the last row requested.
  assign bus.free     = (r_state == StIdle);
  assign bus.valid    = r_valid;
  assign bus.enout    = r_enout;
  assign bus.rom_en   = w_fetch;
  assign bus.rom_addr = w_fetch ? r_cnt[AW-1:0] : r_addr_hold;

endmodule

// File: tb/tb_ldpc_enc_top.sv
// Self-checking bench for ldpc_enc_top: ROM model, GF(2) reference encoder and
// parity-check (H = [P^T | I]) syndrome model.
module tb_ldpc_enc_top;

  localparam int unsigned K  = 128;
  localparam int unsigned AW = 7;

  logic clk;
  logic rst;

  ldpc_enc_top_if #(.K(K), .AW(AW)) bus ();

  ldpc_enc_top #(.K(K), .AW(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [K-1:0] rom [K];

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  int cyc;
  int en_cnt;
  int valid_cnt;
  int addr_err;
  int addr_exp;
  int stab_err;
  logic [2*K-1:0] enout_prev;

  int n_checks;
  int n_fail;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rom_en) begin
      en_cnt = en_cnt + 1;
      if (int'(bus.rom_addr) != addr_exp) addr_err = addr_err + 1;
      addr_exp = addr_exp + 1;
    end else begin
      addr_exp = 0;
    end
    if (bus.valid) valid_cnt = valid_cnt + 1;
    if (!rst && !bus.valid && bus.enout !== enout_prev) stab_err = stab_err + 1;
    enout_prev = bus.enout;
  end

  function automatic logic [K-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [K-1:0] ref_parity(input logic [K-1:0] m);
    logic [K-1:0] p;
    p = '0;
    for (int j = 0; j < int'(K); j++) if (m[j]) p = p ^ rom[j];
    return p;
  endfunction

  function automatic logic [K-1:0] syndrome(input logic [2*K-1:0] c);
    logic [K-1:0] s;
    for (int i = 0; i < int'(K); i++) begin
      s[i] = c[K+i];
      for (int j = 0; j < int'(K); j++) s[i] = s[i] ^ (rom[j][i] & c[j]);
    end
    return s;
  endfunction

  // Starts an encode at the current negedge and returns at the negedge of the valid cycle.
  task automatic run_encode(input logic [K-1:0] m, input bit inject,
                            output logic [2*K-1:0] cw, output int lat,
                            output bit got, output int busy_free);
    int ea;
    bus.work  = 1'b1;
    bus.msg   = m;
    ea        = cyc + 1;
    en_cnt    = 0;
    got       = 1'b0;
    lat       = 0;
    cw        = '0;
    busy_free = 0;
    @(negedge clk);
    bus.work = 1'b0;
    bus.msg  = rand128();
    for (int i = 0; i < int'(K) + 20; i++) begin
      if (bus.valid) begin
        got = 1'b1;
        lat = cyc - ea + 1;
        cw  = bus.enout;
        break;
      end
      if (bus.free) busy_free = busy_free + 1;
      bus.work = inject && (i == 20 || i == 21);
      if (bus.work) bus.msg = rand128();
      @(negedge clk);
    end
    bus.work = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.work = 1'b0;
    bus.msg  = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.free !== 1'b1) begin n_fail++; $display("FAIL reset_free got=%b exp=1", bus.free); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    n_checks++; if (bus.enout !== '0) begin n_fail++; $display("FAIL reset_enout got=%h exp=0", bus.enout); end
    n_checks++; if (bus.rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got=%b exp=0", bus.rom_en); end
    n_checks++; if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=0", bus.rom_addr); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_rom();
    logic [K-1:0] m;
    logic [2*K-1:0] cw;
    int lat, bf;
    bit got;
    for (int j = 0; j < int'(K); j++) rom[j] = '0;
    m = {16{8'hA5}};
    addr_err = 0;
    run_encode(m, 1'b0, cw, lat, got, bf);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL zero_valid_seen got=%b exp=1", got); end
    n_checks++; if (lat != int'(K) + 2) begin n_fail++; $display("FAIL zero_latency got=%0d exp=%0d", lat, K + 2); end
    n_checks++; if (cw[2*K-1:K] !== '0) begin n_fail++; $display("FAIL zero_parity got=%h exp=0", cw[2*K-1:K]); end
    n_checks++; if (cw[K-1:0] !== m) begin n_fail++; $display("FAIL zero_msg got=%h exp=%h", cw[K-1:0], m); end
    n_checks++; if (en_cnt != int'(K)) begin n_fail++; $display("FAIL zero_rom_en_cycles got=%0d exp=%0d", en_cnt, K); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL zero_addr_seq got=%0d exp=0", addr_err); end
    n_checks++; if (bf != 0) begin n_fail++; $display("FAIL zero_free_busy got=%0d exp=0", bf); end
    n_checks++; if (bus.free !== 1'b1) begin n_fail++; $display("FAIL zero_free_valid got=%b exp=1", bus.free); end
    @(negedge clk);
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_pulse got=%b exp=0", bus.valid); end
    n_checks++; if (int'(bus.rom_addr) != int'(K) - 1) begin n_fail++; $display("FAIL zero_addr_hold got=%0d exp=%0d", bus.rom_addr, K - 1); end
  endtask

  task automatic test_identity();
    logic [K-1:0] m;
    logic [2*K-1:0] cw;
    int lat, bf;
    bit got;
    for (int j = 0; j < int'(K); j++) begin
      rom[j]    = '0;
      rom[j][j] = 1'b1;
    end
    m = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    run_encode(m, 1'b0, cw, lat, got, bf);
    n_checks++; if (cw[2*K-1:K] !== m) begin n_fail++; $display("FAIL ident_parity got=%h exp=%h", cw[2*K-1:K], m); end
    n_checks++; if (cw[K-1:0] !== m) begin n_fail++; $display("FAIL ident_msg got=%h exp=%h", cw[K-1:0], m); end
    @(negedge clk);
  endtask

  task automatic test_random_rom();
    logic [K-1:0] m;
    logic [2*K-1:0] cw;
    int lat, bf;
    bit got;
    for (int j = 0; j < int'(K); j++) rom[j] = rand128();
    m = '0;
    run_encode(m, 1'b0, cw, lat, got, bf);
    n_checks++; if (cw !== '0) begin n_fail++; $display("FAIL rand_zero_msg got=%h exp=0", cw); end
    @(negedge clk);
    m = '0;
    m[5] = 1'b1;
    run_encode(m, 1'b0, cw, lat, got, bf);
    n_checks++; if (cw[2*K-1:K] !== rom[5]) begin n_fail++; $display("FAIL rand_bit5 got=%h exp=%h", cw[2*K-1:K], rom[5]); end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      m = rand128();
      run_encode(m, 1'b0, cw, lat, got, bf);
      n_checks++; if (cw !== {ref_parity(m), m}) begin n_fail++; $display("FAIL rand_cw%0d got=%h exp=%h", t, cw, {ref_parity(m), m}); end
      n_checks++; if (syndrome(cw) !== '0) begin n_fail++; $display("FAIL loopback_syndrome%0d got=%h exp=0", t, syndrome(cw)); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [K-1:0] m1, m2;
    logic [2*K-1:0] cw1, cw2;
    int lat1, lat2, bf1, bf2, v0;
    bit got1, got2;
    m1 = rand128();
    m2 = rand128();
    v0 = valid_cnt;
    run_encode(m1, 1'b0, cw1, lat1, got1, bf1);
    run_encode(m2, 1'b1, cw2, lat2, got2, bf2);
    n_checks++; if (cw1 !== {ref_parity(m1), m1}) begin n_fail++; $display("FAIL b2b_cw1 got=%h exp=%h", cw1, {ref_parity(m1), m1}); end
    n_checks++; if (cw2 !== {ref_parity(m2), m2}) begin n_fail++; $display("FAIL b2b_cw2 got=%h exp=%h", cw2, {ref_parity(m2), m2}); end
    n_checks++; if (got2 !== 1'b1 || lat2 != int'(K) + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", lat2, K + 2); end
    repeat (K + 10) @(negedge clk);
    n_checks++; if (valid_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
  endtask

  task automatic test_reset_mid_run();
    logic [K-1:0] m;
    logic [2*K-1:0] cw;
    int lat, bf, v0;
    bit got;
    bus.work = 1'b1;
    bus.msg  = rand128();
    @(negedge clk);
    bus.work = 1'b0;
    repeat (49) @(negedge clk);
    v0  = valid_cnt;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.free !== 1'b1) begin n_fail++; $display("FAIL midrst_free got=%b exp=1", bus.free); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
    n_checks++; if (bus.rom_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rom_en got=%b exp=0", bus.rom_en); end
    n_checks++; if (bus.enout !== '0) begin n_fail++; $display("FAIL midrst_enout got=%h exp=0", bus.enout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (K + 20) @(negedge clk);
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d exp=%0d", valid_cnt, v0); end
    m = rand128();
    run_encode(m, 1'b0, cw, lat, got, bf);
    n_checks++; if (cw !== {ref_parity(m), m}) begin n_fail++; $display("FAIL midrst_cw got=%h exp=%h", cw, {ref_parity(m), m}); end
    n_checks++; if (lat != int'(K) + 2) begin n_fail++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, K + 2); end
    @(negedge clk);
  endtask

  task automatic test_enout_stable();
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL enout_stable got=%0d exp=0", stab_err); end
    n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL addr_sequence got=%0d exp=0", addr_err); end
  endtask

  initial begin
    cyc          = 0;
    en_cnt       = 0;
    valid_cnt    = 0;
    addr_err     = 0;
    addr_exp     = 0;
    stab_err     = 0;
    enout_prev   = '0;
    n_checks     = 0;
    n_fail       = 0;
    bus.rom_data = '0;
    test_reset();
    test_zero_rom();
    test_identity();
    test_random_rom();
    test_back_to_back();
    test_reset_mid_run();
    test_enout_stable();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
